// File: rtl/motor_soft_start.sv
// motor_soft_start: PWM motor drive sequencer with soft-start/soft-stop
// duty ramps, minimum off-time lockout and fault shutdown.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   tick_1hz      1-cycle pulse per second, paces the lockout count
//   tick_ramp     1-cycle pulse, one duty ramp step per pulse
//   motor_req     1 = motor requested on
//   fault_in      1 = fault, forces shutdown
//   pwm_out       registered PWM drive
//   duty          current duty value
//   state         OFF=0 RAMP_UP=1 ON=2 RAMP_DOWN=3 LOCKOUT=4 FAULT=5
//   motor_active  1 in RAMP_UP, ON, RAMP_DOWN
//   lockout       1 in LOCKOUT or FAULT

module motor_soft_start #(
  parameter int PWM_BITS  = 8,
  parameter int RAMP_STEP = 8,
  parameter int LOCKOUT_S = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick_1hz,
  input  logic                tick_ramp,
  input  logic                motor_req,
  input  logic                fault_in,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] duty,
  output logic [2:0]          state,
  output logic                motor_active,
  output logic                lockout
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_UP    = 3'd1,
    S_ON    = 3'd2,
    S_DOWN  = 3'd3,
    S_LOCK  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam int LW =
    (LOCKOUT_S < 1) ? 1 : $clog2(LOCKOUT_S + 1);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [PWM_BITS:0]   STEP_W =
    (PWM_BITS+1)'(RAMP_STEP);
  localparam logic [LW-1:0]       LOCK_INIT =
    LW'(LOCKOUT_S);

  state_t              st;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [LW-1:0]       lock_cnt;

  logic [PWM_BITS:0]   up_sum;
  logic [PWM_BITS-1:0] up_duty;
  logic [PWM_BITS-1:0] dn_duty;

  // One extra bit so the ramp-up add saturates
  // instead of wrapping past full scale.
  assign up_sum  = {1'b0, duty} + STEP_W;
  assign up_duty = (up_sum > {1'b0, DUTY_MAX})
                 ? DUTY_MAX
                 : up_sum[PWM_BITS-1:0];
  assign dn_duty = ({1'b0, duty} > STEP_W)
                 ? duty - STEP_W[PWM_BITS-1:0]
                 : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= S_OFF;
      duty     <= '0;
      pwm_cnt  <= '0;
      pwm_out  <= 1'b0;
      lock_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      // Full scale forces a solid high; otherwise
      // the compare would drop one count per period.
      pwm_out <= (duty == DUTY_MAX) ||
                 (pwm_cnt < duty);

      if (fault_in) begin
        st   <= S_FAULT;
        duty <= '0;
      end else begin
        case (st)
          S_OFF: begin
            duty <= '0;
            if (motor_req)
              st <= S_UP;
          end

          S_UP: begin
            // A reversal wins over a coincident step.
            if (!motor_req) begin
              st <= S_DOWN;
            end else if (tick_ramp) begin
              duty <= up_duty;
              if (up_duty == DUTY_MAX)
                st <= S_ON;
            end
          end

          S_ON: begin
            duty <= DUTY_MAX;
            if (!motor_req)
              st <= S_DOWN;
          end

          S_DOWN: begin
            if (motor_req) begin
              st <= S_UP;
            end else if (tick_ramp) begin
              duty <= dn_duty;
              if (dn_duty == '0) begin
                st       <= S_LOCK;
                lock_cnt <= LOCK_INIT;
              end
            end
          end

          S_LOCK: begin
            duty <= '0;
            if (lock_cnt == '0)
              st <= S_OFF;
            else if (tick_1hz)
              lock_cnt <= lock_cnt - 1'b1;
          end

          S_FAULT: begin
            duty <= '0;
            // The requester must drop motor_req
            // before the fault can clear.
            if (!motor_req) begin
              st       <= S_LOCK;
              lock_cnt <= LOCK_INIT;
            end
          end

          default: begin
            st   <= S_OFF;
            duty <= '0;
          end
        endcase
      end
    end
  end

  assign state        = st;
  assign motor_active = (st == S_UP) ||
                        (st == S_ON) ||
                        (st == S_DOWN);
  assign lockout      = (st == S_LOCK) ||
                        (st == S_FAULT);

endmodule

// File: tb/tb_motor_soft_start.sv
// tb_motor_soft_start: directed scenarios plus randomized
// stimulus against a behavioural model of the sequencer.

module tb_motor_soft_start;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       tick_ramp = 1'b0;
  logic       motor_req = 1'b0;
  logic       fault_in = 1'b0;
  logic       pwm_out;
  logic [7:0] duty;
  logic [2:0] state;
  logic       motor_active;
  logic       lockout;

  int n_checks = 0;
  int n_fail   = 0;

  motor_soft_start #(
    .PWM_BITS (8),
    .RAMP_STEP(8),
    .LOCKOUT_S(3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick_1hz    (tick_1hz),
    .tick_ramp   (tick_ramp),
    .motor_req   (motor_req),
    .fault_in    (fault_in),
    .pwm_out     (pwm_out),
    .duty        (duty),
    .state       (state),
    .motor_active(motor_active),
    .lockout     (lockout)
  );

  always #5 clk = ~clk;

  // Behavioural model: modes as integers, duty as a plain
  // integer clamped to 0..255, PWM from a cycle counter.
  int m_state = 0;
  int m_duty  = 0;
  int m_lock  = 0;
  int m_cyc   = 0;
  bit m_pwm   = 1'b0;

  always @(posedge clk) begin
    int nd;
    if (reset) begin
      m_state = 0;
      m_duty  = 0;
      m_lock  = 0;
      m_cyc   = 0;
      m_pwm   = 1'b0;
    end else begin
      m_pwm = (m_duty == 255) || ((m_cyc % 256) < m_duty);
      m_cyc = m_cyc + 1;
      if (fault_in) begin
        m_state = 5;
        m_duty  = 0;
      end else if (m_state == 0) begin
        m_duty = 0;
        if (motor_req) m_state = 1;
      end else if (m_state == 1) begin
        if (!motor_req) m_state = 3;
        else if (tick_ramp) begin
          nd = m_duty + 8;
          if (nd >= 255) begin
            nd = 255;
            m_state = 2;
          end
          m_duty = nd;
        end
      end else if (m_state == 2) begin
        m_duty = 255;
        if (!motor_req) m_state = 3;
      end else if (m_state == 3) begin
        if (motor_req) m_state = 1;
        else if (tick_ramp) begin
          nd = (m_duty > 8) ? m_duty - 8 : 0;
          m_duty = nd;
          if (nd == 0) begin
            m_state = 4;
            m_lock  = 3;
          end
        end
      end else if (m_state == 4) begin
        m_duty = 0;
        if (m_lock == 0) m_state = 0;
        else if (tick_1hz) m_lock = m_lock - 1;
      end else begin
        m_duty = 0;
        if (!motor_req) begin
          m_state = 4;
          m_lock  = 3;
        end
      end
    end
  end

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic step(input bit rst, input bit rq,
                      input bit ft, input bit tr,
                      input bit t1);
    @(negedge clk);
    reset     = rst;
    motor_req = rq;
    fault_in  = ft;
    tick_ramp = tr;
    tick_1hz  = t1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    n_checks++;
    if (state !== 3'd0 || duty !== 8'd0 ||
        pwm_out !== 1'b0 || lockout !== 1'b0 ||
        motor_active !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pwrup: st=%0d duty=%0d pwm=%b lk=%b act=%b want 0/0/0/0/0",
               state, duty, pwm_out, lockout, motor_active);
    end
    step(0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 1, 0);
    n_checks++;
    if (state !== 3'd1 || duty !== 8'd40) begin
      n_fail++;
      $display("FAIL reset_pre: st=%0d duty=%0d want 1/40",
               state, duty);
    end
    step(1, 1, 0, 1, 0);
    n_checks++;
    if (state !== 3'd0 || duty !== 8'd0 ||
        pwm_out !== 1'b0 || lockout !== 1'b0 ||
        motor_active !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_ramp: st=%0d duty=%0d pwm=%b lk=%b act=%b want 0/0/0/0/0",
               state, duty, pwm_out, lockout, motor_active);
    end
  endtask

  task automatic test_ramp_up;
    int exp_d;
    int exp_s;
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    n_checks++;
    if (state !== 3'd1 || duty !== 8'd0 ||
        motor_active !== 1'b1) begin
      n_fail++;
      $display("FAIL up_enter: st=%0d duty=%0d act=%b want 1/0/1",
               state, duty, motor_active);
    end
    for (int k = 1; k <= 32; k++) begin
      step(0, 1, 0, 1, 0);
      exp_d = (k < 32) ? 8 * k : 255;
      exp_s = (k < 32) ? 1 : 2;
      n_checks++;
      if (duty !== exp_d[7:0] || state !== exp_s[2:0]) begin
        n_fail++;
        $display("FAIL up_tick%0d: st=%0d duty=%0d want %0d/%0d",
                 k, state, duty, exp_s, exp_d);
      end
      step(0, 1, 0, 0, 0);
      n_checks++;
      if (duty !== exp_d[7:0]) begin
        n_fail++;
        $display("FAIL up_hold%0d: duty=%0d want %0d",
                 k, duty, exp_d);
      end
    end
  endtask

  task automatic test_ramp_down;
    int exp_d;
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (state !== 3'd3 || duty !== 8'd255) begin
      n_fail++;
      $display("FAIL down_enter: st=%0d duty=%0d want 3/255",
               state, duty);
    end
    for (int k = 1; k <= 32; k++) begin
      step(0, 0, 0, 1, 0);
      exp_d = (k < 32) ? 255 - 8 * k : 0;
      n_checks++;
      if (duty !== exp_d[7:0] ||
          state !== ((k < 32) ? 3'd3 : 3'd4)) begin
        n_fail++;
        $display("FAIL down_tick%0d: st=%0d duty=%0d want duty %0d",
                 k, state, duty, exp_d);
      end
    end
    // Request is ignored while locked out.
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0, 1);
      n_checks++;
      if (state !== 3'd4 || lockout !== 1'b1) begin
        n_fail++;
        $display("FAIL lockout_hold%0d: st=%0d lk=%b want 4/1",
                 k, state, lockout);
      end
    end
    step(0, 1, 0, 0, 0);
    n_checks++;
    if (state !== 3'd0 || lockout !== 1'b0) begin
      n_fail++;
      $display("FAIL lockout_exit: st=%0d lk=%b want 0/0",
               state, lockout);
    end
    step(0, 1, 0, 0, 0);
    n_checks++;
    if (state !== 3'd1) begin
      n_fail++;
      $display("FAIL off_restart: st=%0d want 1", state);
    end
  endtask

  task automatic test_reversal;
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (state !== 3'd3 || duty !== 8'd64) begin
      n_fail++;
      $display("FAIL rev_down: st=%0d duty=%0d want 3/64",
               state, duty);
    end
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (state !== 3'd3 || duty !== 8'd56) begin
      n_fail++;
      $display("FAIL rev_step: st=%0d duty=%0d want 3/56",
               state, duty);
    end
    step(0, 1, 0, 1, 0);
    n_checks++;
    if (state !== 3'd1 || duty !== 8'd56) begin
      n_fail++;
      $display("FAIL rev_up: st=%0d duty=%0d want 1/56",
               state, duty);
    end
  endtask

  task automatic test_fault;
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int k = 0; k < 32; k++) step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    n_checks++;
    if (state !== 3'd5 || duty !== 8'd0 ||
        pwm_out !== 1'b1 || lockout !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_enter: st=%0d duty=%0d pwm=%b lk=%b want 5/0/1/1",
               state, duty, pwm_out, lockout);
    end
    step(0, 1, 1, 1, 0);
    n_checks++;
    if (state !== 3'd5 || pwm_out !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_pwm: st=%0d pwm=%b want 5/0",
               state, pwm_out);
    end
    step(0, 1, 0, 0, 0);
    n_checks++;
    if (state !== 3'd5) begin
      n_fail++;
      $display("FAIL fault_req_hold: st=%0d want 5", state);
    end
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (state !== 3'd4 || lockout !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_release: st=%0d lk=%b want 4/1",
               state, lockout);
    end
  endtask

  task automatic test_pwm;
    int ones;
    step(1, 0, 0, 0, 0);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      step(0, 0, 0, 0, 0);
      ones += int'(pwm_out);
    end
    n_checks++;
    if (ones != 0) begin
      n_fail++;
      $display("FAIL pwm_duty0: ones=%0d want 0", ones);
    end
    step(0, 1, 0, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      step(0, 1, 0, 0, 0);
      ones += int'(pwm_out);
    end
    n_checks++;
    if (ones != 64 || duty !== 8'd64) begin
      n_fail++;
      $display("FAIL pwm_duty64: ones=%0d duty=%0d want 64/64",
               ones, duty);
    end
    for (int k = 0; k < 24; k++) step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      step(0, 1, 0, 0, 0);
      ones += int'(pwm_out);
    end
    n_checks++;
    if (ones != 256 || state !== 3'd2) begin
      n_fail++;
      $display("FAIL pwm_duty255: ones=%0d st=%0d want 256/2",
               ones, state);
    end
  endtask

  task automatic test_random;
    int fhold;
    bit rq;
    bit exp_act;
    bit exp_lk;
    int bad;
    fhold = 0;
    rq    = 1'b0;
    bad   = 0;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) rq = !rq;
      if (fhold > 0) fhold--;
      else if ($urandom_range(0, 399) == 0)
        fhold = $urandom_range(1, 20);
      step($urandom_range(0, 1499) == 0, rq, fhold > 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 19) == 0);
      exp_act = (m_state >= 1) && (m_state <= 3);
      exp_lk  = (m_state == 4) || (m_state == 5);
      n_checks++;
      if (state !== m_state[2:0] || duty !== m_duty[7:0] ||
          pwm_out !== m_pwm || motor_active !== exp_act ||
          lockout !== exp_lk) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL rand_cyc%0d: st=%0d duty=%0d pwm=%b act=%b lk=%b want %0d/%0d/%b/%b/%b",
                   i, state, duty, pwm_out, motor_active,
                   lockout, m_state, m_duty, m_pwm,
                   exp_act, exp_lk);
      end
    end
  endtask

  initial begin
    test_reset;
    test_ramp_up;
    test_ramp_down;
    test_reversal;
    test_fault;
    test_pwm;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
